// File: rtl/inst_loader.sv
// Push-button instruction loader: synchronises and debounces a raw button,
// then assembles a 12-bit instruction (opcode + 8-bit immediate) nibble by nibble.
module inst_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  input  logic [3:0] data_in,
  input  logic       clr,
  input  logic       cpu_idle,
  output logic       btn_edge,
  output logic       inst_done,
  output logic [3:0] opcode,
  output logic [7:0] imm,
  output logic [1:0] nib_sel
);

  localparam logic [2:0] LOAD_OP = 3'd0;
  localparam logic [2:0] LOAD_LO = 3'd1;
  localparam logic [2:0] LOAD_HI = 3'd2;
  localparam logic [2:0] READY   = 3'd3;
  localparam logic [2:0] EXEC    = 3'd4;

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic        sync1_q, sync2_q;
  logic        stable_q, stable_d;
  logic        stableDly_q;
  logic [15:0] debCount_q, debCount_d;
  logic        pulse_q, pulse_d;

  logic [2:0]  state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [7:0]  imm_q, imm_d;
  logic        seenBusy_q, seenBusy_d;
  logic        instDone_q, instDone_d;

  // Counter only advances on consecutive mismatches; any agreeing sample restarts it.
  always_comb begin
    stable_d   = stable_q;
    debCount_d = '0;
    if (sync2_q != stable_q) begin
      if (debCount_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        debCount_d = debCount_q + 16'd1;
      end
    end
  end

  // Rising edge of the debounced level only; releases never produce a pulse.
  assign pulse_d = stable_q & ~stableDly_q;

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    imm_d      = imm_q;
    seenBusy_d = seenBusy_q;
    if (clr && (state_q != EXEC)) begin
      state_d  = LOAD_OP;
      opcode_d = '0;
      imm_d    = '0;
    end else begin
      case (state_q)
        LOAD_OP: begin
          if (pulse_q) begin
            opcode_d = data_in;
            state_d  = LOAD_LO;
          end
        end
        LOAD_LO: begin
          if (pulse_q) begin
            imm_d[3:0] = data_in;
            state_d    = LOAD_HI;
          end
        end
        LOAD_HI: begin
          if (pulse_q) begin
            imm_d[7:4] = data_in;
            state_d    = READY;
          end
        end
        READY: begin
          if (pulse_q) begin
            state_d = EXEC;
          end
        end
        EXEC: begin
          // The CPU must be seen leaving idle before its return to idle ends execution.
          if (cpu_idle && seenBusy_q) begin
            state_d    = LOAD_OP;
            seenBusy_d = 1'b0;
          end else if (!cpu_idle) begin
            seenBusy_d = 1'b1;
          end
        end
        default: state_d = LOAD_OP;
      endcase
    end
  end

  assign instDone_d = (state_d == READY) || (state_d == EXEC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      stable_q    <= 1'b0;
      stableDly_q <= 1'b0;
      debCount_q  <= '0;
      pulse_q     <= 1'b0;
      state_q     <= LOAD_OP;
      opcode_q    <= '0;
      imm_q       <= '0;
      seenBusy_q  <= 1'b0;
      instDone_q  <= 1'b0;
    end else begin
      sync1_q     <= btn_in;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      stableDly_q <= stable_q;
      debCount_q  <= debCount_d;
      pulse_q     <= pulse_d;
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      imm_q       <= imm_d;
      seenBusy_q  <= seenBusy_d;
      instDone_q  <= instDone_d;
    end
  end

  always_comb begin
    case (state_q)
      LOAD_OP: nib_sel = 2'd0;
      LOAD_LO: nib_sel = 2'd1;
      LOAD_HI: nib_sel = 2'd2;
      default: nib_sel = 2'd3;
    endcase
  end

  assign btn_edge  = pulse_q && (state_q != EXEC);
  assign inst_done = instDone_q;
  assign opcode    = opcode_q;
  assign imm       = imm_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader with the default debounce length of 4.
module tb_inst_loader;

  logic       clk;
  logic       rst_n;
  logic       btn_in;
  logic [3:0] data_in;
  logic       clr;
  logic       cpu_idle;
  logic       btn_edge;
  logic       inst_done;
  logic [3:0] opcode;
  logic [7:0] imm;
  logic [1:0] nib_sel;

  int checks = 0;
  int errors = 0;

  inst_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_in   (btn_in),
    .data_in  (data_in),
    .clr      (clr),
    .cpu_idle (cpu_idle),
    .btn_edge (btn_edge),
    .inst_done(inst_done),
    .opcode   (opcode),
    .imm      (imm),
    .nib_sel  (nib_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; all sampling and driving happens here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pressUntilPulse(input logic [3:0] d);
    bit got;
    got = 0;
    data_in = d;
    btn_in  = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (btn_edge === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL press_timeout: no btn_edge for data %h", d);
    end
  endtask

  task automatic releaseBtn();
    btn_in = 1'b0;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if ({btn_edge, inst_done, opcode, imm, nib_sel} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0000",
               {btn_edge, inst_done, opcode, imm, nib_sel});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_latency();
    data_in = 4'h0;
    btn_in  = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (btn_edge !== (i == 7)) begin
        errors++;
        $display("[TB] FAIL latency_edge%0d: got %b expected %b", i, btn_edge, (i == 7));
      end
    end
    btn_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (btn_edge !== 1'b0) begin
        errors++;
        $display("[TB] FAIL release_no_pulse: got %b expected 0", btn_edge);
      end
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (nib_sel !== 2'd0) begin
      errors++;
      $display("[TB] FAIL latency_clr_nibsel: got %0d expected 0", nib_sel);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 26; i++) begin
      btn_in = (i < 20) ? ((i / 2) % 2 == 0) : 1'b0;
      step();
      checks++;
      if (btn_edge !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bounce_pulse cycle %0d: got %b expected 0", i, btn_edge);
      end
    end
    checks++;
    if (nib_sel !== 2'd0) begin
      errors++;
      $display("[TB] FAIL bounce_nibsel: got %0d expected 0", nib_sel);
    end
  endtask

  task automatic test_load();
    logic [3:0] nibs [3];
    nibs[0] = 4'h8; nibs[1] = 4'h5; nibs[2] = 4'hA;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (nib_sel !== 2'(n)) begin
        errors++;
        $display("[TB] FAIL load_nibsel%0d: got %0d expected %0d", n, nib_sel, n);
      end
      pressUntilPulse(nibs[n]);
      checks++;
      if (inst_done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL load_done_early%0d: got %b expected 0", n, inst_done);
      end
      btn_in = 1'b0;
      step();
      if (n == 2) begin
        checks++;
        if (inst_done !== 1'b1) begin
          errors++;
          $display("[TB] FAIL load_done_rise: got %b expected 1", inst_done);
        end
      end
      releaseBtn();
    end
    checks++;
    if ({opcode, imm, nib_sel} !== {4'h8, 8'hA5, 2'd3}) begin
      errors++;
      $display("[TB] FAIL load_result: got %h expected %h", {opcode, imm, nib_sel}, {4'h8, 8'hA5, 2'd3});
    end
  endtask

  task automatic test_exec();
    pressUntilPulse(4'h3);
    checks++;
    if (inst_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL exec_go_done: got %b expected 1", inst_done);
    end
    releaseBtn();
    data_in = 4'hF;
    btn_in  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if ({btn_edge, nib_sel, inst_done} !== 4'b0111) begin
        errors++;
        $display("[TB] FAIL exec_press: got %b expected 0111", {btn_edge, nib_sel, inst_done});
      end
    end
    releaseBtn();
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if ({opcode, imm, nib_sel} !== {4'h8, 8'hA5, 2'd3}) begin
      errors++;
      $display("[TB] FAIL exec_clr: got %h expected %h", {opcode, imm, nib_sel}, {4'h8, 8'hA5, 2'd3});
    end
    cpu_idle = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (nib_sel !== 2'd3) begin
        errors++;
        $display("[TB] FAIL exec_busy_hold: got %0d expected 3", nib_sel);
      end
    end
    cpu_idle = 1'b1;
    step();
    checks++;
    if ({opcode, imm, nib_sel, inst_done} !== {4'h8, 8'hA5, 2'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL exec_exit: got %h expected %h",
               {opcode, imm, nib_sel, inst_done}, {4'h8, 8'hA5, 2'd0, 1'b0});
    end
  endtask

  task automatic test_loadi();
    pressUntilPulse(4'h7); releaseBtn();
    pressUntilPulse(4'h3); releaseBtn();
    pressUntilPulse(4'hC); releaseBtn();
    pressUntilPulse(4'h0); releaseBtn();
    checks++;
    if ({opcode, imm, nib_sel} !== {4'h7, 8'hC3, 2'd3}) begin
      errors++;
      $display("[TB] FAIL loadi_exec: got %h expected %h", {opcode, imm, nib_sel}, {4'h7, 8'hC3, 2'd3});
    end
    cpu_idle = 1'b0;
    step();
    cpu_idle = 1'b1;
    checks++;
    if (nib_sel !== 2'd3) begin
      errors++;
      $display("[TB] FAIL loadi_busy: got %0d expected 3", nib_sel);
    end
    step();
    checks++;
    if ({nib_sel, inst_done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL loadi_exit: got %b expected 000", {nib_sel, inst_done});
    end
  endtask

  task automatic test_clr();
    pressUntilPulse(4'h2); releaseBtn();
    pressUntilPulse(4'h4); releaseBtn();
    checks++;
    if ({opcode, imm[3:0], nib_sel} !== {4'h2, 4'h4, 2'd2}) begin
      errors++;
      $display("[TB] FAIL clr_setup: got %h expected %h", {opcode, imm[3:0], nib_sel}, {4'h2, 4'h4, 2'd2});
    end
    pressUntilPulse(4'h9);
    clr    = 1'b1;
    btn_in = 1'b0;
    step();
    clr = 1'b0;
    checks++;
    if ({opcode, imm, nib_sel, inst_done} !== 15'h0) begin
      errors++;
      $display("[TB] FAIL clr_abort: got %h expected 0000", {opcode, imm, nib_sel, inst_done});
    end
    releaseBtn();
  endtask

  task automatic test_reset_in_exec();
    int pulses;
    pressUntilPulse(4'hA); releaseBtn();
    pressUntilPulse(4'hB); releaseBtn();
    pressUntilPulse(4'hC); releaseBtn();
    pressUntilPulse(4'h1); releaseBtn();
    cpu_idle = 1'b0;
    step();
    btn_in = 1'b1;
    rst_n  = 1'b0;
    step();
    rst_n    = 1'b1;
    cpu_idle = 1'b1;
    checks++;
    if ({btn_edge, inst_done, opcode, imm, nib_sel} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL exec_reset: got %h expected 0000", {btn_edge, inst_done, opcode, imm, nib_sel});
    end
    pulses  = 0;
    data_in = 4'h6;
    for (int i = 0; i < 15; i++) begin
      step();
      if (btn_edge === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("[TB] FAIL reset_held_pulses: got %0d expected 1", pulses);
    end
    releaseBtn();
    checks++;
    if ({opcode, nib_sel} !== {4'h6, 2'd1}) begin
      errors++;
      $display("[TB] FAIL reset_held_load: got %h expected %h", {opcode, nib_sel}, {4'h6, 2'd1});
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    btn_in   = 1'b0;
    data_in  = 4'h0;
    clr      = 1'b0;
    cpu_idle = 1'b1;
    test_reset();
    test_latency();
    test_bounce();
    test_load();
    test_exec();
    test_loadi();
    test_clr();
    test_reset_in_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
